// File: rtl/toggle_monitor.sv
// Per-bit toggle coverage monitor: pulses o_valid when a bit has been seen both rising and falling.
// Optional macro TOGGLE_ONESHOT_EN: pulse only on each bit's first full toggle since reset/clear.
module toggle_monitor #(
    parameter int WIDTH = 9,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_sig,
    output logic [WIDTH-1:0] o_valid,
    output logic [CW-1:0]    o_covered_cnt,
    output logic             o_all_covered
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_seen_rise;
    logic [WIDTH-1:0] r_seen_fall;
    logic [WIDTH-1:0] r_covered;
    logic [WIDTH-1:0] r_valid;
    logic [CW-1:0]    r_covered_cnt;
    logic             r_all_covered;

    logic             w_sample;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_rise_post;
    logic [WIDTH-1:0] w_fall_post;
    logic [WIDTH-1:0] w_newly_set;
    logic [WIDTH-1:0] w_done;
    logic [WIDTH-1:0] w_seen_rise_nxt;
    logic [WIDTH-1:0] w_seen_fall_nxt;
    logic [WIDTH-1:0] w_covered_nxt;
    logic [CW-1:0]    w_covered_cnt_nxt;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_sample    = (r_state == ST_RUN) && i_en && !i_clear;
        w_rise      = w_sample ? (~r_prev & i_sig) : '0;
        w_fall      = w_sample ? (r_prev & ~i_sig) : '0;
        w_rise_post = r_seen_rise | w_rise;
        w_fall_post = r_seen_fall | w_fall;
        w_newly_set = (w_rise & ~r_seen_rise) | (w_fall & ~r_seen_fall);
        // A toggle completes only when this sample supplied the missing half of the pair.
        w_done      = w_rise_post & w_fall_post & w_newly_set;
`ifdef TOGGLE_ONESHOT_EN
        w_seen_rise_nxt = w_rise_post;
        w_seen_fall_nxt = w_fall_post;
`else
        w_seen_rise_nxt = w_rise_post & ~w_done;
        w_seen_fall_nxt = w_fall_post & ~w_done;
`endif
        w_covered_nxt     = r_covered | w_done;
        w_covered_cnt_nxt = popcount(w_covered_nxt);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_INIT;
            r_prev        <= '0;
            r_seen_rise   <= '0;
            r_seen_fall   <= '0;
            r_covered     <= '0;
            r_valid       <= '0;
            r_covered_cnt <= '0;
            r_all_covered <= 1'b0;
        end else if (i_clear) begin
            r_state       <= ST_INIT;
            r_prev        <= '0;
            r_seen_rise   <= '0;
            r_seen_fall   <= '0;
            r_covered     <= '0;
            r_valid       <= '0;
            r_covered_cnt <= '0;
            r_all_covered <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_valid <= '0;
                    if (i_en) begin
                        r_prev  <= i_sig;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_valid <= w_done;
                    if (i_en) begin
                        r_prev        <= i_sig;
                        r_seen_rise   <= w_seen_rise_nxt;
                        r_seen_fall   <= w_seen_fall_nxt;
                        r_covered     <= w_covered_nxt;
                        r_covered_cnt <= w_covered_cnt_nxt;
                        r_all_covered <= (w_covered_cnt_nxt == CW'(WIDTH));
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_valid <= '0;
                end
            endcase
        end
    end

    assign o_valid       = r_valid;
    assign o_covered_cnt = r_covered_cnt;
    assign o_all_covered = r_all_covered;

endmodule

// File: tb/tb_toggle_monitor.sv
// Randomized and directed bench for toggle_monitor against an event-counting reference model.
module tb_toggle_monitor;

    localparam int W  = 9;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  sig = '0;
    logic [W-1:0]  valid;
    logic [CW-1:0] cnt;
    logic          all_cov;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: counts of rises/falls since the last completed toggle, per bit.
    bit           m_have;
    logic [W-1:0] m_prev;
    int           m_rises [W];
    int           m_falls [W];
    bit           m_cov   [W];
    logic [W-1:0] last_valid;

    toggle_monitor #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_clear      (clr),
        .i_sig        (sig),
        .o_valid      (valid),
        .o_covered_cnt(cnt),
        .o_all_covered(all_cov)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_have = 1'b0;
        m_prev = '0;
        for (int i = 0; i < W; i++) begin
            m_rises[i] = 0;
            m_falls[i] = 0;
            m_cov[i]   = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(m_cov[i]);
        return n;
    endfunction

    task automatic step(input logic e, input logic c, input logic [W-1:0] s, input string tag);
        logic [W-1:0] exp_valid;
        int           exp_cnt;
        bit           fresh;
        @(negedge clk);
        en  = e;
        clr = c;
        sig = s;
        exp_valid = '0;
        if (c) begin
            model_clear();
        end else if (e) begin
            if (!m_have) begin
                m_have = 1'b1;
            end else begin
                for (int i = 0; i < W; i++) begin
                    fresh = 1'b0;
                    if (!m_prev[i] && s[i]) begin
                        if (m_rises[i] == 0) fresh = 1'b1;
                        m_rises[i]++;
                    end
                    if (m_prev[i] && !s[i]) begin
                        if (m_falls[i] == 0) fresh = 1'b1;
                        m_falls[i]++;
                    end
                    if (fresh && m_rises[i] > 0 && m_falls[i] > 0) begin
                        exp_valid[i] = 1'b1;
                        m_cov[i]     = 1'b1;
`ifndef TOGGLE_ONESHOT_EN
                        m_rises[i] = 0;
                        m_falls[i] = 0;
`endif
                    end
                end
            end
            m_prev = s;
        end
        exp_cnt = model_cnt();
        @(posedge clk);
        #1;
        last_valid = valid;
        check({tag, ".valid"}, 64'(valid), 64'(exp_valid));
        check({tag, ".cnt"}, 64'(cnt), 64'(exp_cnt));
        check({tag, ".all"}, 64'(all_cov), 64'(exp_cnt == W));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        #1;
        check("rst.valid", 64'(valid), 64'(0));
        check("rst.cnt", 64'(cnt), 64'(0));
        check("rst.all", 64'(all_cov), 64'(0));
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [W-1:0] s;
        logic e, c;
        model_clear();
        last_valid = '0;
        repeat (2) @(posedge clk);

        // Idle-low signal never produces coverage.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 9'h000, "idle");

        // Single bit 0,1,0 completes on the third sample.
        do_reset();
        step(1'b1, 1'b0, 9'h000, "b0a");
        step(1'b1, 1'b0, 9'h001, "b0b");
        step(1'b1, 1'b0, 9'h000, "b0c");
        check("b0.cnt1", 64'(cnt), 64'(1));

        // Repeated toggles: one pulse in one-shot mode, two otherwise.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, (k % 2 == 1) ? 9'h001 : 9'h000, "rep");
            pulses += int'(last_valid[0]);
        end
`ifdef TOGGLE_ONESHOT_EN
        check("rep.pulses", 64'(pulses), 64'(1));
`else
        check("rep.pulses", 64'(pulses), 64'(2));
`endif
        check("rep.cnt1", 64'(cnt), 64'(1));

        // All bits complete together.
        do_reset();
        step(1'b1, 1'b0, 9'h000, "allA");
        step(1'b1, 1'b0, 9'h1FF, "allB");
        step(1'b1, 1'b0, 9'h000, "allC");
        check("all.cnt9", 64'(cnt), 64'(9));

        // Clear coincident with the completing fall suppresses the pulse.
        do_reset();
        step(1'b1, 1'b0, 9'h000, "clrA");
        step(1'b1, 1'b0, 9'h008, "clrB");
        step(1'b1, 1'b1, 9'h000, "clrC");
        step(1'b1, 1'b0, 9'h008, "clrD");
        step(1'b1, 1'b0, 9'h000, "clrE");

        // Changes while disabled are invisible; re-enable compares with held prev.
        do_reset();
        step(1'b1, 1'b0, 9'h000, "enA");
        step(1'b1, 1'b0, 9'h004, "enB");
        step(1'b0, 1'b0, 9'h000, "enC");
        step(1'b0, 1'b0, 9'h004, "enD");
        step(1'b1, 1'b0, 9'h004, "enE");
        step(1'b1, 1'b0, 9'h000, "enF");

        // Randomized traffic with sparse flips, occasional clear, disable and reset.
        do_reset();
        s = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 150) == 0) do_reset();
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            s = s ^ (W'($urandom) & W'($urandom) & W'($urandom));
            step(e, c, s, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
